cpc_fifo_ctrl: RTL and testbench
================================

CPC_FIFO_CTRL -- requirements
Module: cpc_fifo_ctrl

Interface
REQ-001 The block SHALL have parameter BASE_ADDR, default 16'hFD80, the I/O base: data port at BASE_ADDR, control/status port at BASE_ADDR+1.
REQ-002 The block SHALL have parameter SI_CYCLES, default 1, the host_fifo_si high-pulse width in CLK cycles (1..7).
REQ-003 The block SHALL have parameter SO_CYCLES, default 1, the host_fifo_sob low-pulse width in CLK cycles (1..7).
REQ-004 The block SHALL have parameter RST_CYCLES, default 4, the host_fifo_reset pulse width in CLK cycles (1..15).
REQ-005 CLK  input  1  Z80 system clock; all state on rising edge; there is one clock.
REQ-006 RESET  input  1  asynchronous, active-high reset.
REQ-007 A  input  16  Z80 address bus.
REQ-008 D_IN  input  8  Z80 data bus, sampled for control-port writes.
REQ-009 D_OUT  output  8  status byte driven to the data bus.
REQ-010 D_OE  output  1  high = block drives D_OUT onto the data bus.
REQ-011 IOREQ_B, RD_B, WR_B, M1_B  input  1 each  Z80 strobes, active-low, synchronous to CLK.
REQ-012 fifo_host_dir  input  1  outbound FIFO can accept a byte.
REQ-013 fifo_host_dor  input  1  inbound FIFO holds a byte.
REQ-014 host_fifo_si  output  1  outbound FIFO shift-in, active-high.
REQ-015 host_fifo_sob  output  1  inbound FIFO shift-out, active-low.
REQ-016 host_fifo_oeb  output  1  inbound FIFO output enable, active-low.
REQ-017 host_fifo_reset  output  1  master reset to both FIFOs, active-high.

Function
REQ-018 Decode SHALL be: io_sel = !IOREQ_B & M1_B & (A[15:1]==BASE_ADDR[15:1]); rd = io_sel & !RD_B; wr = io_sel & !WR_B; port = A[0].
REQ-019 An access start SHALL be the first cycle in which rd|wr is high after being low the previous cycle (registered edge detect); starts SHALL be accepted only in state IDLE and ignored otherwise (no bus drive, no FIFO strobes, no flag change).
REQ-020 FSM states SHALL be INIT, IDLE, RD_DATA, SO_PULSE, SI_PULSE, RD_STAT, HOLD, CMD_RST.
REQ-021 INIT: host_fifo_reset=1 for RST_CYCLES cycles after RESET deasserts, then IDLE.
REQ-022 IDLE, start, port 0, rd, fifo_host_dor=1: next cycle host_fifo_oeb=0 (RD_DATA) until rd low, then SO_PULSE: host_fifo_sob=0 for SO_CYCLES cycles, then IDLE.
REQ-023 IDLE, start, port 0, rd, fifo_host_dor=0: set sticky UNDERFLOW, drive D_OUT=8'hFF with D_OE=1 until rd low (RD_STAT), then IDLE; host_fifo_oeb and host_fifo_sob SHALL stay 1.
REQ-024 IDLE, start, port 0, wr, fifo_host_dir=1: next cycle host_fifo_si=1 for SI_CYCLES cycles (SI_PULSE), then HOLD until wr low, then IDLE.
REQ-025 IDLE, start, port 0, wr, fifo_host_dir=0: set sticky OVERFLOW, no host_fifo_si pulse, HOLD until wr low.
REQ-026 IDLE, start, port 1, rd: status captured at start cycle, D_OUT={3'b000, busy, UNDERFLOW, OVERFLOW, fifo_host_dir, fifo_host_dor}, D_OE=1 from next cycle until rd low (RD_STAT), then IDLE; busy is always 0 when captured from IDLE.
REQ-027 IDLE, start, port 1, wr: D_IN[1]=1 clears OVERFLOW and UNDERFLOW; D_IN[0]=1 enters CMD_RST (host_fifo_reset=1 for RST_CYCLES cycles, flags also cleared), then HOLD until wr low, then IDLE; D_IN[0]=0 goes to HOLD.
REQ-028 If IOREQ_B rises during SI_PULSE or SO_PULSE the pulse SHALL still complete its full width.
REQ-029 At most one FIFO shift SHALL occur per access; host_fifo_si and host_fifo_sob SHALL never be active in the same cycle, and neither SHALL be active while host_fifo_reset=1.
REQ-030 D_OE and !host_fifo_oeb SHALL never be high in the same cycle.
REQ-031 Pulse counters SHALL be 3 bits (SI/SO) and 4 bits (RST) and SHALL not wrap.

Reset
REQ-032 While RESET=1: state INIT, host_fifo_reset=1, host_fifo_si=0, host_fifo_sob=1, host_fifo_oeb=1, D_OE=0, D_OUT=8'h00, OVERFLOW=UNDERFLOW=0, counters 0.
REQ-033 RESET asserted mid-access SHALL abort it immediately with the values of REQ-032; the interrupted access SHALL NOT be restarted after release.

Verification
REQ-034 RESET release -> host_fifo_reset high exactly 4 cycles, then IDLE, all strobes idle.
REQ-035 OUT (&FD80),&5A with dir=1 -> single host_fifo_si high for 1 cycle; second OUT with dir=0 -> no SI, status read returns bit2=1.
REQ-036 IN (&FD80) with dor=1 -> host_fifo_oeb low through read, then host_fifo_sob low 1 cycle after RD_B rises; with dor=0 -> D_OUT=&FF, D_OE=1, no sob, status bit3=1.
REQ-037 IN (&FD81) with dir=1, dor=0, flags clear -> D_OUT=8'h02.
REQ-038 OUT (&FD81),&01 -> host_fifo_reset 4 cycles, flags cleared; IN (&FD80) during CMD_RST ignored.
REQ-039 IOREQ_B low with M1_B low (interrupt acknowledge) at A=&FD80, and access at A=&FD82 -> no response.

Source files
------------

// File: rtl/cpc_fifo_ctrl.sv
// Z80 I/O front end for a pair of host FIFOs: decodes a data port and a
// control/status port, sequences FIFO strobes and keeps sticky error flags.
//
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   INIT     | FIFO master reset pulse after RESET release
//   IDLE     | waiting for a new Z80 access start
//   RD_DATA  | inbound FIFO output enabled onto the bus until read ends
//   SO_PULSE | inbound FIFO shift-out pulse after the read
//   SI_PULSE | outbound FIFO shift-in pulse after a data write
//   RD_STAT  | block drives D_OUT (status byte or underflow 8'hFF)
//   HOLD     | waiting for the write strobe to drop
//   CMD_RST  | FIFO master reset pulse requested by a control write
module cpc_fifo_ctrl #(
    parameter logic [15:0] BASE_ADDR  = 16'hFD80,
    parameter int          SI_CYCLES  = 1,
    parameter int          SO_CYCLES  = 1,
    parameter int          RST_CYCLES = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [15:0] A,
    input  logic [7:0]  D_IN,
    output logic [7:0]  D_OUT,
    output logic        D_OE,
    input  logic        IOREQ_B,
    input  logic        RD_B,
    input  logic        WR_B,
    input  logic        M1_B,
    input  logic        fifo_host_dir,
    input  logic        fifo_host_dor,
    output logic        host_fifo_si,
    output logic        host_fifo_sob,
    output logic        host_fifo_oeb,
    output logic        host_fifo_reset
);

    typedef enum logic [2:0] {
        INIT, IDLE, RD_DATA, SO_PULSE, SI_PULSE, RD_STAT, HOLD, CMD_RST
    } state_t;

    localparam logic [2:0] SI_LAST  = 3'(SI_CYCLES - 1);
    localparam logic [2:0] SO_LAST  = 3'(SO_CYCLES - 1);
    localparam logic [3:0] RST_LAST = 4'(RST_CYCLES - 1);

    state_t      state_q, state_d;
    logic        acc_q;
    logic        ovf_q, ovf_d;
    logic        unf_q, unf_d;
    logic [7:0]  dout_q, dout_d;
    logic [2:0]  pcnt_q, pcnt_d;
    logic [3:0]  rcnt_q, rcnt_d;

    logic io_sel, rd, wr, port, start;
    logic unused_din;

    // M1_B low with IOREQ_B low is an interrupt acknowledge, never an I/O access
    assign io_sel     = !IOREQ_B && M1_B && (A[15:1] == BASE_ADDR[15:1]);
    assign rd         = io_sel && !RD_B;
    assign wr         = io_sel && !WR_B;
    assign port       = A[0];
    assign start      = (rd || wr) && !acc_q;
    assign unused_din = ^D_IN[7:2];

    // State, flags, captured read byte, pulse counters and access edge detect
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= INIT;
            acc_q   <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            dout_q  <= 8'h00;
            pcnt_q  <= 3'd0;
            rcnt_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            acc_q   <= rd || wr;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            dout_q  <= dout_d;
            pcnt_q  <= pcnt_d;
            rcnt_q  <= rcnt_d;
        end
    end

    // Next-state logic; counters return to zero whenever their pulse ends
    always_comb begin
        state_d = state_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        dout_d  = dout_q;
        pcnt_d  = pcnt_q;
        rcnt_d  = rcnt_q;
        case (state_q)
            INIT: begin
                if (rcnt_q == RST_LAST) begin
                    rcnt_d  = 4'd0;
                    state_d = IDLE;
                end else begin
                    rcnt_d = rcnt_q + 4'd1;
                end
            end
            IDLE: begin
                if (start) begin
                    if (!port) begin
                        if (rd) begin
                            if (fifo_host_dor) begin
                                state_d = RD_DATA;
                            end else begin
                                unf_d   = 1'b1;
                                dout_d  = 8'hFF;
                                state_d = RD_STAT;
                            end
                        end else begin
                            if (fifo_host_dir) begin
                                state_d = SI_PULSE;
                            end else begin
                                ovf_d   = 1'b1;
                                state_d = HOLD;
                            end
                        end
                    end else begin
                        if (rd) begin
                            // busy reads 0: a status capture only happens from IDLE
                            dout_d  = {3'b000, 1'b0, unf_q, ovf_q, fifo_host_dir, fifo_host_dor};
                            state_d = RD_STAT;
                        end else begin
                            if (D_IN[1] || D_IN[0]) begin
                                ovf_d = 1'b0;
                                unf_d = 1'b0;
                            end
                            state_d = D_IN[0] ? CMD_RST : HOLD;
                        end
                    end
                end
            end
            RD_DATA: begin
                if (!rd) state_d = SO_PULSE;
            end
            SO_PULSE: begin
                if (pcnt_q == SO_LAST) begin
                    pcnt_d  = 3'd0;
                    state_d = IDLE;
                end else begin
                    pcnt_d = pcnt_q + 3'd1;
                end
            end
            SI_PULSE: begin
                if (pcnt_q == SI_LAST) begin
                    pcnt_d  = 3'd0;
                    state_d = HOLD;
                end else begin
                    pcnt_d = pcnt_q + 3'd1;
                end
            end
            RD_STAT: begin
                if (!rd) state_d = IDLE;
            end
            HOLD: begin
                if (!wr) state_d = IDLE;
            end
            CMD_RST: begin
                if (rcnt_q == RST_LAST) begin
                    rcnt_d  = 4'd0;
                    state_d = HOLD;
                end else begin
                    rcnt_d = rcnt_q + 4'd1;
                end
            end
            default: state_d = INIT;
        endcase
    end

    // Strobes and bus drive are pure functions of state, so they cannot overlap
    always_comb begin
        host_fifo_reset = 1'b0;
        host_fifo_si    = 1'b0;
        host_fifo_sob   = 1'b1;
        host_fifo_oeb   = 1'b1;
        D_OE            = 1'b0;
        D_OUT           = 8'h00;
        case (state_q)
            INIT, CMD_RST: host_fifo_reset = 1'b1;
            RD_DATA:       host_fifo_oeb   = 1'b0;
            SO_PULSE:      host_fifo_sob   = 1'b0;
            SI_PULSE:      host_fifo_si    = 1'b1;
            RD_STAT: begin
                D_OE  = 1'b1;
                D_OUT = dout_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cpc_fifo_ctrl.sv
module tb_cpc_fifo_ctrl;

    localparam logic [15:0] BASE = 16'hFD80;
    localparam int SI_C  = 1;
    localparam int SO_C  = 1;
    localparam int RST_C = 4;

    localparam int EV_SI  = 1;
    localparam int EV_SO  = 2;
    localparam int EV_OEB = 3;
    localparam int EV_OE  = 4;
    localparam int EV_RST = 5;

    typedef struct {
        int         kind;
        int         width;
        logic [7:0] data;
    } ev_t;

    logic        CLK;
    logic        RESET;
    logic [15:0] A;
    logic [7:0]  D_IN;
    logic [7:0]  D_OUT;
    logic        D_OE;
    logic        IOREQ_B, RD_B, WR_B, M1_B;
    logic        fifo_host_dir, fifo_host_dor;
    logic        host_fifo_si, host_fifo_sob, host_fifo_oeb, host_fifo_reset;

    ev_t exp_q[$];
    int  n_chk  = 0;
    int  n_pass = 0;

    // reference model state: sticky flags
    bit m_ovf = 0;
    bit m_unf = 0;

    cpc_fifo_ctrl #(
        .BASE_ADDR (BASE),
        .SI_CYCLES (SI_C),
        .SO_CYCLES (SO_C),
        .RST_CYCLES(RST_C)
    ) dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .A              (A),
        .D_IN           (D_IN),
        .D_OUT          (D_OUT),
        .D_OE           (D_OE),
        .IOREQ_B        (IOREQ_B),
        .RD_B           (RD_B),
        .WR_B           (WR_B),
        .M1_B           (M1_B),
        .fifo_host_dir  (fifo_host_dir),
        .fifo_host_dor  (fifo_host_dor),
        .host_fifo_si   (host_fifo_si),
        .host_fifo_sob  (host_fifo_sob),
        .host_fifo_oeb  (host_fifo_oeb),
        .host_fifo_reset(host_fifo_reset)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic void push_ev(input int kind, input int width, input logic [7:0] data);
        ev_t e;
        e.kind  = kind;
        e.width = width;
        e.data  = data;
        exp_q.push_back(e);
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %02h, required %02h", name, act, req);
    endtask

    task automatic report(input int kind, input int width, input logic [7:0] data);
        ev_t e;
        n_chk++;
        if (exp_q.size() == 0) begin
            $display("FAIL unexpected_event: got kind=%0d width=%0d data=%02h, required no event",
                     kind, width, data);
        end else begin
            e = exp_q.pop_front();
            if (e.kind == kind && e.width == width && e.data == data) n_pass++;
            else $display("FAIL event: got kind=%0d width=%0d data=%02h, required kind=%0d width=%0d data=%02h",
                          kind, width, data, e.kind, e.width, e.data);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_reset"}, {7'd0, host_fifo_reset}, 8'h01);
        chk({tag, "_si"},    {7'd0, host_fifo_si},    8'h00);
        chk({tag, "_sob"},   {7'd0, host_fifo_sob},   8'h01);
        chk({tag, "_oeb"},   {7'd0, host_fifo_oeb},   8'h01);
        chk({tag, "_doe"},   {7'd0, D_OE},            8'h00);
        chk({tag, "_dout"},  D_OUT,                   8'h00);
    endtask

    // Monitor: measures each strobe run and reports it when it ends
    int         si_run = 0, sob_run = 0, oeb_run = 0, oe_run = 0, rst_run = 0;
    logic [7:0] oe_data = 8'h00;
    always @(negedge CLK) begin
        if (RESET) begin
            si_run = 0; sob_run = 0; oeb_run = 0; oe_run = 0; rst_run = 0;
        end else begin
            n_chk++;
            if ((host_fifo_si && !host_fifo_sob) ||
                (host_fifo_reset && (host_fifo_si || !host_fifo_sob)) ||
                (D_OE && !host_fifo_oeb))
                $display("FAIL protocol: got si=%b sob=%b rst=%b oe=%b oeb=%b, required no overlap",
                         host_fifo_si, host_fifo_sob, host_fifo_reset, D_OE, host_fifo_oeb);
            else n_pass++;

            if (host_fifo_si) si_run++;
            else if (si_run > 0) begin report(EV_SI, si_run, 8'h00); si_run = 0; end
            if (!host_fifo_sob) sob_run++;
            else if (sob_run > 0) begin report(EV_SO, sob_run, 8'h00); sob_run = 0; end
            if (!host_fifo_oeb) oeb_run++;
            else if (oeb_run > 0) begin report(EV_OEB, oeb_run, 8'h00); oeb_run = 0; end
            if (host_fifo_reset) rst_run++;
            else if (rst_run > 0) begin report(EV_RST, rst_run, 8'h00); rst_run = 0; end
            if (D_OE) begin
                if (oe_run == 0) oe_data = D_OUT;
                oe_run++;
            end else if (oe_run > 0) begin
                report(EV_OE, oe_run, oe_data);
                oe_run = 0;
            end
        end
    end

    // One Z80 I/O access; the model predicts its strobe/bus events from the rules
    task automatic bus_op(input bit wr, input logic [15:0] addr, input bit m1_b,
                          input logic [7:0] din, input int len, input bit dir,
                          input bit dor, input int gap, input bit ignored);
        if (!ignored && m1_b && addr[15:1] == BASE[15:1]) begin
            if (!addr[0]) begin
                if (!wr) begin
                    if (dor) begin
                        push_ev(EV_OEB, len, 8'h00);
                        push_ev(EV_SO, SO_C, 8'h00);
                    end else begin
                        m_unf = 1;
                        push_ev(EV_OE, len, 8'hFF);
                    end
                end else begin
                    if (dir) push_ev(EV_SI, SI_C, 8'h00);
                    else m_ovf = 1;
                end
            end else begin
                if (!wr) begin
                    push_ev(EV_OE, len, {4'b0000, m_unf, m_ovf, dir, dor});
                end else begin
                    if (din[1] || din[0]) begin m_ovf = 0; m_unf = 0; end
                    if (din[0]) push_ev(EV_RST, RST_C, 8'h00);
                end
            end
        end
        @(posedge CLK); #1;
        fifo_host_dir = dir;
        fifo_host_dor = dor;
        A       = addr;
        D_IN    = din;
        M1_B    = m1_b;
        IOREQ_B = 1'b0;
        RD_B    = wr;
        WR_B    = !wr;
        repeat (len) @(posedge CLK);
        #1;
        IOREQ_B = 1'b1;
        RD_B    = 1'b1;
        WR_B    = 1'b1;
        M1_B    = 1'b1;
        repeat (gap) @(posedge CLK);
    endtask

    initial begin
        logic [15:0] addr;
        logic [7:0]  din;
        bit          m1b, wr;
        int          r;

        RESET = 1'b1; A = 16'h0000; D_IN = 8'h00;
        IOREQ_B = 1'b1; RD_B = 1'b1; WR_B = 1'b1; M1_B = 1'b1;
        fifo_host_dir = 1'b0; fifo_host_dor = 1'b0;
        push_ev(EV_RST, RST_C, 8'h00);
        repeat (3) @(negedge CLK);
        chk_reset_vals("por");
        @(posedge CLK); #1;
        RESET = 1'b0;
        repeat (8) @(posedge CLK);

        // data writes: accepted, then refused with overflow
        bus_op(1, BASE,     1, 8'h5A, 2, 1, 0, 12, 0);
        bus_op(1, BASE,     1, 8'h33, 2, 0, 0, 12, 0);
        bus_op(0, BASE + 1, 1, 8'h00, 2, 1, 0, 12, 0);
        // data reads: good then underflow, then status
        bus_op(0, BASE,     1, 8'h00, 3, 0, 1, 12, 0);
        bus_op(0, BASE,     1, 8'h00, 2, 0, 0, 12, 0);
        bus_op(0, BASE + 1, 1, 8'h00, 1, 0, 1, 12, 0);
        // flag clear, then clean status
        bus_op(1, BASE + 1, 1, 8'h02, 1, 1, 0, 12, 0);
        bus_op(0, BASE + 1, 1, 8'h00, 2, 1, 0, 12, 0);
        // interrupt acknowledge and out-of-window address
        bus_op(0, BASE,     0, 8'h00, 2, 1, 1, 12, 0);
        bus_op(1, 16'hFD82, 1, 8'h01, 2, 1, 1, 12, 0);
        bus_op(0, 16'hFD83, 1, 8'h00, 2, 1, 1, 12, 0);
        // command reset with a data read issued while it runs
        bus_op(1, BASE,     1, 8'h00, 1, 0, 0, 12, 0);
        bus_op(1, BASE + 1, 1, 8'h01, 1, 1, 1, 0, 0);
        bus_op(0, BASE,     1, 8'h00, 2, 1, 1, 12, 1);
        bus_op(0, BASE + 1, 1, 8'h00, 1, 1, 0, 12, 0);

        // reset in the middle of a data read aborts it for good
        bus_op(1, BASE, 1, 8'h00, 1, 0, 0, 12, 0);
        @(posedge CLK); #1;
        fifo_host_dor = 1'b1; A = BASE; IOREQ_B = 1'b0; RD_B = 1'b0;
        repeat (2) @(posedge CLK); #1;
        RESET = 1'b1;
        @(negedge CLK);
        chk_reset_vals("mid");
        @(posedge CLK); #1;
        m_ovf = 0; m_unf = 0;
        push_ev(EV_RST, RST_C, 8'h00);
        RESET = 1'b0;
        repeat (2) @(posedge CLK); #1;
        IOREQ_B = 1'b1; RD_B = 1'b1;
        repeat (12) @(posedge CLK);
        bus_op(0, BASE + 1, 1, 8'h00, 1, 0, 1, 12, 0);

        // randomized traffic
        for (int i = 0; i < 200; i++) begin
            r    = $urandom_range(0, 9);
            wr   = $urandom_range(0, 1);
            m1b  = 1'b1;
            addr = BASE + 16'($urandom_range(0, 1));
            if (r == 0) addr = 16'hFD82 + 16'($urandom_range(0, 1));
            else if (r == 1) m1b = 1'b0;
            din    = 8'($urandom_range(0, 255));
            din[0] = ($urandom_range(0, 3) == 0);
            bus_op(wr, addr, m1b, din, $urandom_range(1, 4),
                   $urandom_range(0, 1), $urandom_range(0, 1), 12, 0);
        end

        repeat (20) @(posedge CLK);
        chk("scoreboard_drain", 8'(exp_q.size()), 8'h00);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
